// File: rtl/uart_rx_timing_if.sv
// Signal bundle between a UART receive-timing core and its user: line/config
// inputs toward the core, timing strobes and status back from it.
interface uart_rx_timing_if #(
    parameter int DIV_W = 16
);
    logic             Enable;
    logic [DIV_W-1:0] Div_Val;
    logic             RX_Pin;
    logic             Sample_Tick;
    logic             Bit_Strobe;
    logic             Bit_Val;
    logic             Frame_Start;
    logic             Frame_End;
    logic             Frame_Err;
    logic             Start_Reject;
    logic             Busy;

    modport master (
        output Enable, Div_Val, RX_Pin,
        input  Sample_Tick, Bit_Strobe, Bit_Val, Frame_Start, Frame_End,
               Frame_Err, Start_Reject, Busy
    );

    modport slave (
        input  Enable, Div_Val, RX_Pin,
        output Sample_Tick, Bit_Strobe, Bit_Val, Frame_Start, Frame_End,
               Frame_Err, Start_Reject, Busy
    );
endinterface

// File: rtl/uart_rx_timing.sv
// UART receive timing: oversampled start/data/stop tracking with 2-of-3 majority
// voting per bit; emits bit strobes and frame status pulses.
module uart_rx_timing #(
    parameter int DIV_W     = 16,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8
) (
    input  logic            CLK,
    input  logic            RSTn,
    uart_rx_timing_if.slave rx_if
);
    localparam int OS_W = $clog2(OVS);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0]  OS_S0   = OS_W'(OVS / 2 - 1);
    localparam logic [OS_W-1:0]  OS_S1   = OS_W'(OVS / 2);
    localparam logic [OS_W-1:0]  OS_MAJ  = OS_W'(OVS / 2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVS - 1);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state_reg, state_next;

    logic             rx_meta_reg, rx_s_reg, rx_prev_reg;
    logic [DIV_W-1:0] div_reg, presc_reg;
    logic [OS_W-1:0]  os_reg;
    logic [BC_W-1:0]  bit_cnt_reg;
    logic             samp0_reg, samp1_reg;
    logic             bit_val_reg, bit_strobe_reg, frame_start_reg;
    logic             frame_end_reg, frame_err_reg, start_reject_reg;

    logic tick, maj_tick, last_tick, majority, start_edge;
    logic bit_strobe_next, frame_end_next, start_reject_next;

    assign tick      = (state_reg != IDLE) && rx_if.Enable && (presc_reg == div_reg - DIV_W'(1));
    assign maj_tick  = tick && (os_reg == OS_MAJ);
    assign last_tick = tick && (os_reg == OS_LAST);
    assign majority  = (samp0_reg & samp1_reg) | (samp0_reg & rx_s_reg) | (samp1_reg & rx_s_reg);

    // STOP hands over to IDLE on its majority tick, so an edge landing in that
    // very cycle is accepted to keep back-to-back frames intact.
    assign start_edge = rx_if.Enable && rx_prev_reg && !rx_s_reg &&
                        ((state_reg == IDLE) || ((state_reg == STOP) && maj_tick));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        bit_strobe_next   = 1'b0;
        frame_end_next    = 1'b0;
        start_reject_next = 1'b0;
        if (!rx_if.Enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_edge) state_next = START;
                end
                START: begin
                    if (maj_tick && majority) begin
                        start_reject_next = 1'b1;
                        state_next        = IDLE;
                    end else if (last_tick) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (maj_tick) bit_strobe_next = 1'b1;
                    if (last_tick && (bit_cnt_reg == BC_LAST)) state_next = STOP;
                end
                STOP: begin
                    if (maj_tick) begin
                        frame_end_next = 1'b1;
                        state_next     = start_edge ? START : IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rx_meta_reg      <= 1'b1;
            rx_s_reg         <= 1'b1;
            // Cleared so a line held low through reset is not taken as an edge.
            rx_prev_reg      <= 1'b0;
            div_reg          <= DIV_MIN;
            presc_reg        <= '0;
            os_reg           <= '0;
            bit_cnt_reg      <= '0;
            samp0_reg        <= 1'b0;
            samp1_reg        <= 1'b0;
            bit_val_reg      <= 1'b0;
            bit_strobe_reg   <= 1'b0;
            frame_start_reg  <= 1'b0;
            frame_end_reg    <= 1'b0;
            frame_err_reg    <= 1'b0;
            start_reject_reg <= 1'b0;
        end else begin
            rx_meta_reg      <= rx_if.RX_Pin;
            rx_s_reg         <= rx_meta_reg;
            rx_prev_reg      <= rx_s_reg;
            bit_strobe_reg   <= bit_strobe_next;
            frame_end_reg    <= frame_end_next;
            start_reject_reg <= start_reject_next;
            frame_start_reg  <= start_edge;

            if (bit_strobe_next) bit_val_reg <= majority;

            if (frame_end_next)  frame_err_reg <= ~majority;
            else if (start_edge) frame_err_reg <= 1'b0;

            if (start_edge) begin
                div_reg <= (rx_if.Div_Val < DIV_MIN) ? DIV_MIN : rx_if.Div_Val;
            end

            if (start_edge || !rx_if.Enable) begin
                presc_reg   <= '0;
                os_reg      <= '0;
                bit_cnt_reg <= '0;
            end else if (state_reg != IDLE) begin
                if (tick) begin
                    presc_reg <= '0;
                    os_reg    <= (os_reg == OS_LAST) ? '0 : os_reg + OS_W'(1);
                end else begin
                    presc_reg <= presc_reg + DIV_W'(1);
                end
                if (tick && (os_reg == OS_S0)) samp0_reg <= rx_s_reg;
                if (tick && (os_reg == OS_S1)) samp1_reg <= rx_s_reg;
                if ((state_reg == START) && (state_next == DATA)) begin
                    bit_cnt_reg <= '0;
                end else if (bit_strobe_next) begin
                    bit_cnt_reg <= bit_cnt_reg + BC_W'(1);
                end
            end
        end
    end

    assign rx_if.Sample_Tick  = tick;
    assign rx_if.Bit_Strobe   = bit_strobe_reg;
    assign rx_if.Bit_Val      = bit_val_reg;
    assign rx_if.Frame_Start  = frame_start_reg;
    assign rx_if.Frame_End    = frame_end_reg;
    assign rx_if.Frame_Err    = frame_err_reg;
    assign rx_if.Start_Reject = start_reject_reg;
    assign rx_if.Busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx_timing.sv
// Directed bench for uart_rx_timing: table of frames plus hand-written
// sequences for false start, glitch, back-to-back, enable drop and reset.
`timescale 1ns/1ps
module tb_uart_rx_timing;
    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    uart_rx_timing_if #(.DIV_W(16)) bus();

    uart_rx_timing #(.DIV_W(16), .OVS(16), .DATA_BITS(8)) dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .rx_if (bus)
    );

    int errors = 0;
    int checks = 0;

    // Pulse monitor: running totals, sampled on the falling edge.
    int   n_tick = 0, n_strobe = 0, n_start = 0, n_end = 0, n_reject = 0;
    logic bit_hist [0:1023];
    logic err_at_start = 1'b0;
    logic busy_after_reject = 1'b1;
    logic reject_d = 1'b0;

    always @(negedge CLK) begin
        if (RSTn) begin
            if (reject_d) busy_after_reject = bus.Busy;
            reject_d = bus.Start_Reject;
            if (bus.Sample_Tick)  n_tick++;
            if (bus.Frame_Start) begin
                n_start++;
                err_at_start = bus.Frame_Err;
            end
            if (bus.Frame_End)    n_end++;
            if (bus.Start_Reject) n_reject++;
            if (bus.Bit_Strobe) begin
                bit_hist[n_strobe[9:0]] = bus.Bit_Val;
                n_strobe++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int cpb, input int glitch_bit);
        bus.RX_Pin = 1'b0;
        wait_clk(cpb);
        for (int b = 0; b < 8; b++) begin
            bus.RX_Pin = data[b];
            if (b == glitch_bit) begin
                wait_clk(cpb / 2 + 2);
                bus.RX_Pin = ~data[b];
                wait_clk(cpb / 16);
                bus.RX_Pin = data[b];
                wait_clk(cpb - cpb / 2 - 2 - cpb / 16);
            end else begin
                wait_clk(cpb);
            end
        end
        bus.RX_Pin = stop;
        wait_clk(cpb);
        bus.RX_Pin = 1'b1;
    endtask

    function automatic int bits_from(input int base);
        int v = 0;
        for (int i = 0; i < 8; i++) if (bit_hist[base + i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int outs_vec();
        return {bus.Sample_Tick, bus.Bit_Strobe, bus.Bit_Val, bus.Frame_Start,
                bus.Frame_End, bus.Frame_Err, bus.Start_Reject, bus.Busy};
    endfunction

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [15:0] div;
        int          cpb;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];
    int b_start, b_strobe, b_end, b_rej, b_tick;

    task automatic snap();
        b_start = n_start; b_strobe = n_strobe; b_end = n_end;
        b_rej = n_reject; b_tick = n_tick;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 16'd4, 64, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 16'd4, 64, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 16'd4, 64, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 16'd6, 96, 1'b0};
        vecs[4] = '{8'h5A, 1'b1, 16'd1, 32, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 16'd0, 32, 1'b0};

        bus.Enable  = 1'b1;
        bus.Div_Val = 16'd4;
        bus.RX_Pin  = 1'b1;
        #12;
        check("reset_outputs", outs_vec(), 0);
        @(negedge CLK);
        RSTn = 1'b1;
        wait_clk(5);

        for (int i = 0; i < 6; i++) begin
            snap();
            bus.Div_Val = vecs[i].div;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].cpb, -1);
            wait_clk(4);
            $display("vector %0d: data=%02h stop=%0b div=%0d", i, vecs[i].data, vecs[i].stop, vecs[i].div);
            check("frame_start_cnt", n_start - b_start, 1);
            check("bit_strobe_cnt", n_strobe - b_strobe, 8);
            check("frame_end_cnt", n_end - b_end, 1);
            check("reject_cnt", n_reject - b_rej, 0);
            check("sample_tick_cnt", n_tick - b_tick, 154);
            check("bit_values", bits_from(b_strobe), int'(vecs[i].data));
            check("bit_val_held", int'(bus.Bit_Val), int'(vecs[i].data[7]));
            check("frame_err", int'(bus.Frame_Err), int'(vecs[i].exp_err));
            check("err_cleared_at_start", int'(err_at_start), 0);
            check("busy_after_stop", int'(bus.Busy), 0);
            wait_clk(20);
        end

        // False start: 3 oversample ticks low on an idle line.
        bus.Div_Val = 16'd4;
        snap();
        bus.RX_Pin = 1'b0;
        wait_clk(12);
        bus.RX_Pin = 1'b1;
        wait_clk(80);
        $display("sequence: false start");
        check("reject_cnt", n_reject - b_rej, 1);
        check("reject_strobes", n_strobe - b_strobe, 0);
        check("reject_end", n_end - b_end, 0);
        check("busy_after_reject", int'(busy_after_reject), 0);

        // Inverted one-tick glitch on the middle sample of bit 3.
        snap();
        send_frame(8'hFF, 1'b1, 64, 3);
        wait_clk(4);
        $display("sequence: glitch on bit 3");
        check("glitch_strobes", n_strobe - b_strobe, 8);
        check("glitch_bits", bits_from(b_strobe), 8'hFF);

        // Back-to-back frames; divisor change during frame 1 applies to frame 2.
        wait_clk(20);
        snap();
        fork
            begin
                send_frame(8'h55, 1'b1, 64, -1);
                send_frame(8'hAA, 1'b1, 128, -1);
            end
            begin
                wait_clk(200);
                bus.Div_Val = 16'd8;
            end
        join
        wait_clk(4);
        $display("sequence: back-to-back");
        check("b2b_strobes", n_strobe - b_strobe, 16);
        check("b2b_ends", n_end - b_end, 2);
        check("b2b_starts", n_start - b_start, 2);
        check("b2b_frame1", bits_from(b_strobe), 8'h55);
        check("b2b_frame2", bits_from(b_strobe + 8), 8'hAA);
        check("b2b_err", int'(bus.Frame_Err), 0);

        // Enable dropped during data bit 2.
        bus.Div_Val = 16'd4;
        wait_clk(20);
        snap();
        fork
            send_frame(8'h0F, 1'b1, 64, -1);
            begin
                wait_clk(64 * 3);
                bus.Enable = 1'b0;
                wait_clk(2);
                check("disable_busy", int'(bus.Busy), 0);
            end
        join
        wait_clk(4);
        $display("sequence: enable drop");
        check("disable_strobes", n_strobe - b_strobe, 2);
        check("disable_end", n_end - b_end, 0);
        bus.Enable = 1'b1;
        wait_clk(20);
        snap();
        send_frame(8'hC3, 1'b1, 64, -1);
        wait_clk(4);
        check("reenable_bits", bits_from(b_strobe), 8'hC3);

        // Asynchronous reset in data bit 4, then a clean frame.
        wait_clk(20);
        snap();
        fork
            send_frame(8'hFF, 1'b1, 64, -1);
            begin
                wait_clk(64 * 5 + 20);
                check("pre_reset_busy", int'(bus.Busy), 1);
                check("pre_reset_bitval", int'(bus.Bit_Val), 1);
                #3;
                RSTn = 1'b0;
                #1;
                check("midframe_reset_outputs", outs_vec(), 0);
                wait_clk(3);
                RSTn = 1'b1;
            end
        join
        wait_clk(10);
        $display("sequence: reset mid-frame");
        check("reset_frame_end", n_end - b_end, 0);
        snap();
        send_frame(8'hA5, 1'b1, 64, -1);
        wait_clk(4);
        check("post_reset_strobes", n_strobe - b_strobe, 8);
        check("post_reset_bits", bits_from(b_strobe), 8'hA5);
        check("post_reset_err", int'(bus.Frame_Err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_timing.md
UART_RX_TIMING -- requirements
Module: uart_rx_timing

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the runtime divisor.
REQ-002 SHALL have parameter OVS, default 16, oversample ticks per bit; legal values are even numbers >= 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range is 5..9.
REQ-004 SHALL have port CLK  input  1  system clock.
REQ-005 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Enable  input  1  receiver enable; low forces IDLE.
REQ-007 SHALL have port Div_Val  input  DIV_W  CLK cycles per oversample tick.
REQ-008 SHALL have port RX_Pin  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port Sample_Tick  output  1  one-CLK oversample tick pulse, active only while not IDLE.
REQ-010 SHALL have port Bit_Strobe  output  1  one-CLK pulse per received data bit.
REQ-011 SHALL have port Bit_Val  output  1  majority-voted data bit value, valid while Bit_Strobe is high and held afterwards.
REQ-012 SHALL have port Frame_Start  output  1  one-CLK pulse on an accepted start edge.
REQ-013 SHALL have port Frame_End  output  1  one-CLK pulse at stop-bit evaluation.
REQ-014 SHALL have port Frame_Err  output  1  stop bit sampled low; held until the next Frame_Start.
REQ-015 SHALL have port Start_Reject  output  1  one-CLK pulse when a false start is discarded.
REQ-016 SHALL have port Busy  output  1  high in every state except IDLE.

Function
REQ-017 RX_Pin SHALL pass through a 2-flop synchronizer, both flops reset to 1; all logic uses the synchronized value rx_s.
REQ-018 The start edge SHALL be detected as rx_s previous = 1 and rx_s current = 0, in IDLE, with Enable = 1.
REQ-019 On a start edge, the block SHALL latch Div_Val into an internal divisor; Div_Val < 2 latches as 2; Div_Val changes mid-frame have no effect.
REQ-020 The prescaler SHALL count 0..div-1 and assert Sample_Tick when count = div-1; the prescaler and the oversample counter clear on the start edge.
REQ-021 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-022 IDLE -> START SHALL occur on the start edge, with Frame_Start pulsed in the following cycle.
REQ-023 In each bit period, rx_s SHALL be sampled on the ticks where the oversample count equals OVS/2-1, OVS/2 and OVS/2+1; the 2-of-3 majority is formed on the OVS/2+1 tick.
REQ-024 START with majority = 1 SHALL pulse Start_Reject and return to IDLE; with majority = 0, the FSM SHALL enter DATA on the OVS-1 tick, with the counter wrapping to 0.
REQ-025 DATA SHALL register Bit_Val and pulse Bit_Strobe in the cycle after each majority tick, LSB first.
REQ-026 After DATA_BITS bits, the FSM SHALL enter STOP on the OVS-1 tick.
REQ-027 STOP SHALL, at the majority tick, pulse Frame_End, set Frame_Err = ~majority, and go directly to IDLE, without waiting for the bit end, so that back-to-back frames are received.
REQ-028 A start edge that coincides with the STOP->IDLE transition cycle SHALL be accepted.
REQ-029 Enable = 0 in any state SHALL move the FSM to IDLE next cycle, clear the counters, and suppress all pulses; Frame_Err and Bit_Val retain their values.
REQ-030 The data-bit counter width SHALL be $clog2(DATA_BITS+1), and the oversample counter width SHALL be $clog2(OVS); counters SHALL never exceed their terminal values.

Reset
REQ-031 RSTn = 0 SHALL asynchronously force the FSM to IDLE, all counters to 0, synchronizer flops to 1, and every output to 0, including mid-frame.
REQ-032 After reset release, no start edge SHALL be detected until rx_s has been seen high for at least one cycle.

Verification
REQ-033 Div_Val = 4, OVS = 16, frame 0xA5 with a valid stop bit -> Frame_Start x1; Bit_Strobe x8 with Bit_Val 1,0,1,0,0,1,0,1; Frame_End x1; Frame_Err = 0; Busy low after STOP.
REQ-034 Low pulse of 3 oversample ticks on an idle line -> Start_Reject x1, no Bit_Strobe, Busy low 1 cycle later.
REQ-035 Frame 0x3C with stop bit 0 -> Frame_End with Frame_Err = 1; Frame_Err clears on the next Frame_Start.
REQ-036 A 1-tick inverted glitch at the mid-sample of data bit 3 of 0xFF -> all Bit_Val = 1, since the majority vote corrects it.
REQ-037 Two back-to-back frames 0x55 and 0xAA with one stop bit -> 16 Bit_Strobe pulses, 2 Frame_End pulses, both values correct; Div_Val changed mid-frame 1 has no effect until frame 2.
REQ-038 RSTn asserted during data bit 4 -> all outputs 0 immediately; the next frame after release is received correctly.
